reg_heap_mp: RTL and testbench

//  Parametrised multi-read-port register file with a per-register busy scoreboard, for the CPU datapath.

---
 rtl/reg_heap_pkg.sv | 17 +
 rtl/reg_heap_rdport.sv | 56 +++++
 rtl/reg_heap_mp.sv | 98 +++++++++
 tb/tb_reg_heap_mp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_heap_pkg.sv
// Shared constants, types and helpers for the multi-port register heap.
// Optional feature macro: REG_HEAP_BYPASS_EN (write-through forwarding on read ports).
package reg_heap_pkg;

    localparam int DW_DEF        = 32;
    localparam int AW_DEF        = 5;
    localparam int NUM_RD_DEF    = 2;
    localparam int REG_ZERO_ADDR = 0;

    typedef logic [DW_DEF-1:0] reg_word_t;

    // True when the hard-wired zero register exists and the address selects it.
    function automatic logic is_zero_hit(input logic [31:0] addr_ext, input logic zero_en);
        return zero_en && (addr_ext == 32'(REG_ZERO_ADDR));
    endfunction

endpackage

// File: rtl/reg_heap_rdport.sv
// One combinational read port of reg_heap_mp: address mux, zero-register
// override and, when REG_HEAP_BYPASS_EN is defined, write-through forwarding.
module reg_heap_rdport
    import reg_heap_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic [(1<<AW)-1:0][DW-1:0] mem_i,
    input  logic [(1<<AW)-1:0]         busy_i,
    input  logic [AW-1:0]              ra_i,
    input  logic                       s_write_i,
    input  logic [AW-1:0]              rd_i,
    input  logic [DW-1:0]              wdata_i,
    input  logic                       rsv_en_i,
    input  logic [AW-1:0]              rsv_addr_i,
    output logic [DW-1:0]              rdata_o,
    output logic                       rbusy_o
);

    logic zero_hit_s;

`ifdef REG_HEAP_BYPASS_EN
    logic fwd_hit_s;
`else
    // Write/reserve inputs only matter for forwarding; tie them off here.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{s_write_i, rd_i, wdata_i, rsv_en_i, rsv_addr_i};
`endif

    // Select stored data/busy for the addressed register, with overrides.
    always_comb begin
        zero_hit_s = is_zero_hit(32'(ra_i), ZERO_REG != 0);
        rdata_o    = mem_i[ra_i];
        rbusy_o    = busy_i[ra_i];
`ifdef REG_HEAP_BYPASS_EN
        fwd_hit_s  = s_write_i && (rd_i == ra_i) && !zero_hit_s;
`endif
        if (zero_hit_s) begin
            rdata_o = {DW{1'b0}};
            rbusy_o = 1'b0;
`ifdef REG_HEAP_BYPASS_EN
        end else if (fwd_hit_s) begin
            // The write clears busy, but a same-cycle reserve to the same
            // register keeps it marked.
            rdata_o = wdata_i;
            rbusy_o = rsv_en_i && (rsv_addr_i == ra_i);
`endif
        end else begin
            rdata_o = mem_i[ra_i];
            rbusy_o = busy_i[ra_i];
        end
    end

endmodule

// File: rtl/reg_heap_mp.sv
// Parametrised multi-read-port register file with a per-register busy
// scoreboard and a registered count of busy registers.
// Optional feature macro: REG_HEAP_BYPASS_EN (write-through forwarding).
module reg_heap_mp
    import reg_heap_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NUM_RD*AW-1:0] ra,
    output logic [NUM_RD*DW-1:0] rdata,
    output logic [NUM_RD-1:0]    rbusy,
    input  logic [AW-1:0]        rd,
    input  logic                 s_write,
    input  logic [DW-1:0]        W,
    input  logic [AW-1:0]        rsv_addr,
    input  logic                 rsv_en,
    output logic [AW:0]          busy_cnt
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [AW:0]              busy_cnt_q, busy_cnt_d;

    logic wr_en_s;
    logic rsv_en_s;
    logic cnt_inc_s;
    logic cnt_dec_s;

    // Next-state for storage, busy bits and the busy population count.
    always_comb begin
        wr_en_s  = s_write && !is_zero_hit(32'(rd), ZERO_REG != 0);
        rsv_en_s = rsv_en  && !is_zero_hit(32'(rsv_addr), ZERO_REG != 0);
        mem_d    = mem_q;
        busy_d   = busy_q;

        if (wr_en_s) begin
            mem_d[rd]  = W;
            busy_d[rd] = 1'b0;
        end else begin
            mem_d = mem_q;
        end

        // Applied after the write so a same-address reserve wins.
        if (rsv_en_s) begin
            busy_d[rsv_addr] = 1'b1;
        end else begin
            busy_d[rsv_addr] = busy_d[rsv_addr];
        end

        // A reserve counts only if the bit was clear; a write counts only if
        // it clears a set bit that a same-address reserve does not re-set.
        cnt_inc_s  = rsv_en_s && !busy_q[rsv_addr];
        cnt_dec_s  = wr_en_s && busy_q[rd] && !(rsv_en_s && (rsv_addr == rd));
        busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, cnt_inc_s} - {{AW{1'b0}}, cnt_dec_s};
    end

    // State registers; clr discards any write or reserve in the same cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem_q      <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        reg_heap_rdport #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .mem_i      (mem_q),
            .busy_i     (busy_q),
            .ra_i       (ra[i*AW +: AW]),
            .s_write_i  (s_write),
            .rd_i       (rd),
            .wdata_i    (W),
            .rsv_en_i   (rsv_en),
            .rsv_addr_i (rsv_addr),
            .rdata_o    (rdata[i*DW +: DW]),
            .rbusy_o    (rbusy[i])
        );
    end

endmodule

// File: tb/tb_reg_heap_mp.sv
// Self-checking bench for reg_heap_mp (default parameters, two read ports).
// Directed table, a scoreboard-fill sequence, then random stimulus against
// an array-based reference model. Honours REG_HEAP_BYPASS_EN if defined.
module tb_reg_heap_mp;
    import reg_heap_pkg::*;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 2;

    logic                 clk;
    logic                 clr;
    logic [NUM_RD*AW-1:0] ra;
    logic [NUM_RD*DW-1:0] rdata;
    logic [NUM_RD-1:0]    rbusy;
    logic [AW-1:0]        rd;
    logic                 s_write;
    logic [DW-1:0]        W;
    logic [AW-1:0]        rsv_addr;
    logic                 rsv_en;
    logic [AW:0]          busy_cnt;

    int checks = 0;
    int errors = 0;

    reg_word_t mem_m  [32];
    bit        busy_m [32];

    typedef struct {
        logic        c;
        logic        wr;
        logic [4:0]  a_rd;
        logic [31:0] w;
        logic        rs;
        logic [4:0]  a_rs;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e_d0;
        logic        e_b0;
        logic [31:0] e_d1;
        logic        e_b1;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [21];

    reg_heap_mp dut (
        .clk      (clk),
        .clr      (clr),
        .ra       (ra),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .rd       (rd),
        .s_write  (s_write),
        .W        (W),
        .rsv_addr (rsv_addr),
        .rsv_en   (rsv_en),
        .busy_cnt (busy_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic c, input logic wr, input logic [4:0] a_rd,
                                input logic [31:0] w, input logic rs, input logic [4:0] a_rs,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] e_d0, input logic e_b0,
                                input logic [31:0] e_d1, input logic e_b1,
                                input logic [5:0] e_cnt);
        vec_t v;
        v.c = c; v.wr = wr; v.a_rd = a_rd; v.w = w; v.rs = rs; v.a_rs = a_rs;
        v.r0 = r0; v.r1 = r1; v.e_d0 = e_d0; v.e_b0 = e_b0;
        v.e_d1 = e_d1; v.e_b1 = e_b1; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs settle by return.
    task automatic drive(input logic c, input logic wr, input logic [4:0] a_rd,
                         input logic [31:0] w, input logic rs, input logic [4:0] a_rs,
                         input logic [4:0] r0, input logic [4:0] r1);
        @(negedge clk);
        clr = c; s_write = wr; rd = a_rd; W = w;
        rsv_en = rs; rsv_addr = a_rs; ra = {r1, r0};
        #2;
    endtask

    // Take the rising edge and advance the reference model with the same inputs.
    task automatic edge_and_model();
        @(posedge clk);
        if (clr) begin
            for (int k = 0; k < 32; k++) begin
                mem_m[k]  = '0;
                busy_m[k] = 1'b0;
            end
        end else begin
            if (s_write && rd != 5'd0) begin
                mem_m[rd]  = W;
                busy_m[rd] = 1'b0;
            end
            if (rsv_en && rsv_addr != 5'd0) busy_m[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    function automatic logic [31:0] m_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REG_HEAP_BYPASS_EN
        if (s_write && rd == a) return W;
`endif
        return mem_m[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef REG_HEAP_BYPASS_EN
        if (s_write && rd == a) return rsv_en && (rsv_addr == a);
`endif
        return busy_m[a];
    endfunction

    function automatic logic [31:0] m_cnt();
        int n = 0;
        for (int k = 0; k < 32; k++) n += int'(busy_m[k]);
        return 32'(n);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_rdata0"}, rdata[31:0],  m_data(ra[4:0]));
        chk({tag, "_rbusy0"}, 32'(rbusy[0]), 32'(m_busy(ra[4:0])));
        chk({tag, "_rdata1"}, rdata[63:32], m_data(ra[9:5]));
        chk({tag, "_rbusy1"}, 32'(rbusy[1]), 32'(m_busy(ra[9:5])));
        chk({tag, "_cnt"},    32'(busy_cnt), m_cnt());
    endtask

    initial begin
        logic [31:0] byp_exp;
        vec_t v;
`ifdef REG_HEAP_BYPASS_EN
        byp_exp = 32'h0000_0055;
`else
        byp_exp = 32'h0000_00aa;
`endif
        // Args: clr, wr, rd, W, rsv, rsv_addr, ra0, ra1 | rdata0, rbusy0, rdata1, rbusy1, cnt
        tbl[0]  = mk(1'b0, 1'b1, 5'd4, 32'h1234, 1'b0, 5'd0, 5'd1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[1]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0, 32'h1234, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[2]  = mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0, 32'h1234, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[3]  = mk(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[4]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[5]  = mk(1'b0, 1'b1, 5'd4, 32'habcd, 1'b0, 5'd0, 5'd2, 5'd2, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[6]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd2, 32'habcd, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[7]  = mk(1'b0, 1'b1, 5'd0, 32'hffff_ffff, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[8]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd4, 32'h0, 1'b0, 32'habcd, 1'b0, 6'd0);
        tbl[9]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[10] = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 6'd1);
        tbl[11] = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 5'd9, 32'h0, 1'b1, 32'h0, 1'b0, 6'd1);
        tbl[12] = mk(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 5'd9, 5'd4, 32'h0, 1'b1, 32'habcd, 1'b0, 6'd2);
        tbl[13] = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd9, 32'h77, 1'b0, 32'h0, 1'b1, 6'd1);
        tbl[14] = mk(1'b0, 1'b1, 5'd5, 32'h5555, 1'b1, 5'd5, 5'd9, 5'd4, 32'h0, 1'b1, 32'habcd, 1'b0, 6'd1);
        tbl[15] = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9, 32'h5555, 1'b1, 32'h0, 1'b1, 6'd2);
        tbl[16] = mk(1'b1, 1'b1, 5'd6, 32'h6666, 1'b0, 5'd0, 5'd5, 5'd4, 32'h5555, 1'b1, 32'habcd, 1'b0, 6'd2);
        tbl[17] = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd5, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[18] = mk(1'b0, 1'b1, 5'd3, 32'haa, 1'b0, 5'd0, 5'd2, 5'd2, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tbl[19] = mk(1'b0, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 5'd2, 5'd3, 32'h0, 1'b0, byp_exp, 1'b0, 6'd0);
        tbl[20] = mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd3, 32'h0, 1'b0, 32'h55, 1'b0, 6'd0);

        clr = 1'b1; s_write = 1'b0; rd = '0; W = '0; rsv_en = 1'b0; rsv_addr = '0; ra = '0;

        // Initial reset to bring storage out of the unknown state.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        edge_and_model();

        // Directed table.
        for (int i = 0; i < 21; i++) begin
            v = tbl[i];
            drive(v.c, v.wr, v.a_rd, v.w, v.rs, v.a_rs, v.r0, v.r1);
            chk($sformatf("tbl%0d_rdata0", i), rdata[31:0],   v.e_d0);
            chk($sformatf("tbl%0d_rbusy0", i), 32'(rbusy[0]), 32'(v.e_b0));
            chk($sformatf("tbl%0d_rdata1", i), rdata[63:32],  v.e_d1);
            chk($sformatf("tbl%0d_rbusy1", i), 32'(rbusy[1]), 32'(v.e_b1));
            chk($sformatf("tbl%0d_cnt", i),    32'(busy_cnt), 32'(v.e_cnt));
            edge_and_model();
        end

        // Scoreboard fill: reserve every non-zero register, count reaches 31.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        edge_and_model();
        for (int a = 1; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'd0, 5'd0);
            edge_and_model();
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd31, 5'd0);
        chk("fill_cnt", 32'(busy_cnt), 32'd31);
        chk("fill_rbusy31", 32'(rbusy[0]), 32'd1);
        chk("fill_rbusy0", 32'(rbusy[1]), 32'd0);
        edge_and_model();
        drive(1'b0, 1'b1, 5'd31, 32'hdead_beef, 1'b0, 5'd0, 5'd31, 5'd1);
        chk("rereserve_cnt", 32'(busy_cnt), 32'd31);
        edge_and_model();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd1);
        chk("drain_cnt", 32'(busy_cnt), 32'd30);
        chk("drain_rdata31", rdata[31:0], 32'hdead_beef);
        chk("drain_rbusy31", 32'(rbusy[0]), 32'd0);
        chk("drain_rbusy1", 32'(rbusy[1]), 32'd1);
        edge_and_model();

        // Random traffic against the reference model.
        for (int n = 0; n < 500; n++) begin
            logic [4:0] rmax;
            rmax = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
            drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, int'(rmax))),
                  $urandom(),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, int'(rmax))),
                  5'($urandom_range(0, int'(rmax))),
                  5'($urandom_range(0, int'(rmax))));
            check_model($sformatf("rnd%0d", n));
            edge_and_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
